// File: rtl/gcd_core.sv
// Subtractive-Euclid GCD compute stage: accepts operands on a start pulse,
// iterates one subtraction per enabled edge and emits a one-cycle done pulse.
module gcd_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_result_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic [WIDTH-1:0] w_a_minus_b;
    logic [WIDTH-1:0] w_b_minus_a;

    // Only the difference selected by the a>b / a<b compare is used, so no wrap.
    assign w_a_minus_b = r_a - r_b;
    assign w_b_minus_a = r_b - r_a;

    always_comb begin
        w_state_next  = r_state;
        w_a_next      = r_a;
        w_b_next      = r_b;
        w_result_next = r_result;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_next     = a_in;
                    w_b_next     = b_in;
                    w_busy_next  = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                // Priority order matters: a zero operand terminates before the equality test.
                if (r_a == '0) begin
                    w_result_next = r_b;
                    w_done_next   = 1'b1;
                    w_busy_next   = 1'b0;
                    w_state_next  = S_IDLE;
                end else if (r_b == '0) begin
                    w_result_next = r_a;
                    w_done_next   = 1'b1;
                    w_busy_next   = 1'b0;
                    w_state_next  = S_IDLE;
                end else if (r_a == r_b) begin
                    w_result_next = r_a;
                    w_done_next   = 1'b1;
                    w_busy_next   = 1'b0;
                    w_state_next  = S_IDLE;
                end else if (r_a > r_b) begin
                    w_a_next = w_a_minus_b;
                end else begin
                    w_b_next = w_b_minus_a;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (clk_en) begin
            r_state  <= w_state_next;
            r_a      <= w_a_next;
            r_b      <= w_b_next;
            r_result <= w_result_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
